// File: rtl/fp32_div_seq_pkg.sv
// Shared binary32 constants, field accessors and divider FSM states.
// Imported by the divider top and by the special-operand classifier.
package fp32_div_seq_pkg;

   localparam int          WIDTH    = 32;
   localparam int          QBITS    = 26;
   localparam logic [7:0]  EXP_BIAS = 8'd127;
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF  = 32'h7F80_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      ROUND  = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic fp_sign(input logic [31:0] x);
      return x[31];
   endfunction

   function automatic logic [7:0] fp_exp(input logic [31:0] x);
      return x[30:23];
   endfunction

   function automatic logic [22:0] fp_frac(input logic [22:0] x);
      return x;
   endfunction

endpackage

// File: rtl/fp32_special_detect.sv
// Combinational classifier for a binary32 operand pair (denormals read as zero).
// Flags operand pairs whose quotient is fixed by IEEE rules and supplies that word.
module fp32_special_detect
   import fp32_div_seq_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        special,
   output logic [31:0] result
);

   logic sign;
   logic a_zero, a_inf, a_nan;
   logic b_zero, b_inf, b_nan;

   always_comb begin
      sign   = fp_sign(a) ^ fp_sign(b);
      a_zero = (fp_exp(a) == 8'h00);
      b_zero = (fp_exp(b) == 8'h00);
      a_inf  = (fp_exp(a) == 8'hFF) && (fp_frac(a[22:0]) == 23'd0);
      b_inf  = (fp_exp(b) == 8'hFF) && (fp_frac(b[22:0]) == 23'd0);
      a_nan  = (fp_exp(a) == 8'hFF) && (fp_frac(a[22:0]) != 23'd0);
      b_nan  = (fp_exp(b) == 8'hFF) && (fp_frac(b[22:0]) != 23'd0);

      special = 1'b1;
      result  = QNAN;
      // Earlier branches win: NaN-producing cases must beat the x/0 infinity.
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         result = QNAN;
      end else if (b_zero || a_inf) begin
         result = POS_INF | {sign, 31'd0};
      end else if (a_zero || b_inf) begin
         result = {sign, 31'd0};
      end else begin
         special = 1'b0;
         result  = 32'd0;
      end
   end

endmodule

// File: rtl/fp32_div_seq.sv
// Iterative binary32 divider: one restoring quotient bit per falling edge,
// then a single round-to-nearest-even step; valid/ready on both sides.
module fp32_div_seq
   import fp32_div_seq_pkg::*;
(
   input  logic        clk_n,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Result
);

   // Handshake: a transfer happens on the falling edge where valid and ready
   // are both high; out_valid/Result then hold until out_ready is seen high.

   state_t            state;
   logic [4:0]        cnt;
   logic [24:0]       rem;
   logic [25:0]       q;
   logic [23:0]       mb;
   logic signed [9:0] exp_r;
   logic              sign_r;

   logic              special;
   logic [31:0]       special_result;

   fp32_special_detect u_special (
      .a       (A),
      .b       (B),
      .special (special),
      .result  (special_result)
   );

   logic signed [9:0] exp_start;
   logic              rem_ge;
   logic [24:0]       rem_diff;
   logic              norm;
   logic [23:0]       mant_pre;
   logic              guard, rnd, sticky, round_up;
   logic [24:0]       mant_sum;
   logic signed [9:0] exp_norm, exp_fin;
   logic [22:0]       frac_fin;
   logic [31:0]       packed_result;

   always_comb begin
      exp_start = $signed({2'b00, fp_exp(A)}) - $signed({2'b00, fp_exp(B)})
                + $signed({2'b00, EXP_BIAS});
      rem_ge    = (rem >= {1'b0, mb});
      rem_diff  = rem - {1'b0, mb};

      // A leading zero quotient bit means ma < mb: realign by one position.
      norm     = q[25];
      mant_pre = norm ? q[25:2] : q[24:1];
      guard    = norm ? q[1] : q[0];
      rnd      = norm ? q[0] : 1'b0;
      sticky   = |rem;
      exp_norm = norm ? exp_r : exp_r - 10'sd1;

      round_up = guard & (rnd | sticky | mant_pre[0]);
      mant_sum = {1'b0, mant_pre} + {24'd0, round_up};
      exp_fin  = mant_sum[24] ? exp_norm + 10'sd1 : exp_norm;
      frac_fin = mant_sum[24] ? mant_sum[23:1] : mant_sum[22:0];

      if (exp_fin >= 10'sd255) begin
         packed_result = {sign_r, 8'hFF, 23'd0};
      end else if (exp_fin <= 10'sd0) begin
         packed_result = {sign_r, 31'd0};
      end else begin
         packed_result = {sign_r, exp_fin[7:0], frac_fin};
      end
   end

   always_ff @(negedge clk_n or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         Result    <= 32'd0;
         cnt       <= 5'd0;
         rem       <= 25'd0;
         q         <= 26'd0;
         mb        <= 24'd0;
         exp_r     <= 10'sd0;
         sign_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (special) begin
                     Result    <= special_result;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     rem    <= {2'b01, A[22:0]};
                     mb     <= {1'b1, B[22:0]};
                     q      <= 26'd0;
                     exp_r  <= exp_start;
                     sign_r <= A[31] ^ B[31];
                     cnt    <= 5'(QBITS - 1);
                     state  <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               if (rem_ge) begin
                  rem <= {rem_diff[23:0], 1'b0};
                  q   <= {q[24:0], 1'b1};
               end else begin
                  rem <= {rem[23:0], 1'b0};
                  q   <= {q[24:0], 1'b0};
               end
               cnt <= cnt - 5'd1;
               if (cnt == 5'd0) begin
                  state <= ROUND;
               end
            end
            ROUND: begin
               Result    <= packed_result;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed-vector bench for fp32_div_seq: driver pushes expected quotients and
// latencies, an independent monitor pops and compares on each output transfer.
module tb_fp32_div_seq;

   logic        clk_n     = 1'b1;
   logic        rst_n     = 1'b0;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a_in      = 32'd0;
   logic [31:0] b_in      = 32'd0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] result;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   int          lat_q[$];
   int          cyc     = 0;
   int          acc_cyc = 0;
   logic        prev_ov = 1'b0;

   fp32_div_seq dut (
      .clk_n     (clk_n),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a_in),
      .B         (b_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Result    (result)
   );

   // Clock and reset: DUT acts on falling edges, bench samples on rising edges.
   initial forever #5 clk_n = ~clk_n;

   always @(negedge clk_n) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Driver: waits for in_ready, queues the expectation, presents one operand pair.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int lat);
      int n = 0;
      @(posedge clk_n); #1;
      while (!in_ready && n < 200) begin
         @(posedge clk_n); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1 for A=%h B=%h", a, b);
         return;
      end
      exp_q.push_back(exp_res);
      lat_q.push_back(lat);
      a_in     = a;
      b_in     = b;
      in_valid = 1'b1;
      @(negedge clk_n); #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      a_in     = $urandom();
      b_in     = $urandom();
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
         @(posedge clk_n);
         n++;
      end
      if (exp_q.size() != 0 || !in_ready) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
      #1;
   endtask

   // Scoreboard monitor: latency on each out_valid rise, value on each transfer.
   always @(posedge clk_n) begin
      if (!rst_n) begin
         prev_ov = 1'b0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (lat_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL latency: got unexpected out_valid expected none");
            end else begin
               check_int("latency", cyc - acc_cyc, lat_q.pop_front());
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL result: got unexpected %h expected none", result);
            end else begin
               check32("result", result, exp_q.pop_front());
            end
         end
         prev_ov = out_valid;
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      int          lat;
   } vec_t;

   vec_t vecs[19];

   initial begin
      int n;

      vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 27};
      vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 27};
      vecs[2]  = '{32'h40000000, 32'h3F800000, 32'h40000000, 27};
      vecs[3]  = '{32'h3F800000, 32'h40000000, 32'h3F000000, 27};
      vecs[4]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 27};
      vecs[5]  = '{32'h3FC00000, 32'h3FC00000, 32'h3F800000, 27};
      vecs[6]  = '{32'h3F800000, 32'h3F7FFFFF, 32'h3F800001, 27};
      vecs[7]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 0};
      vecs[8]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 0};
      vecs[9]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 0};
      vecs[10] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 0};
      vecs[11] = '{32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 27};
      vecs[12] = '{32'h00800000, 32'h7F7FFFFF, 32'h00000000, 27};
      vecs[13] = '{32'h00000001, 32'h3F800000, 32'h00000000, 0};
      vecs[14] = '{32'h40400000, 32'h7F800000, 32'h00000000, 0};
      vecs[15] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 0};
      vecs[16] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 0};
      vecs[17] = '{32'h80000000, 32'h40A00000, 32'h80000000, 0};
      vecs[18] = '{32'h00000000, 32'h7F800000, 32'h00000000, 0};

      // Reset state
      repeat (3) @(posedge clk_n);
      check_int("rst_in_ready", int'(in_ready), 1);
      check_int("rst_out_valid", int'(out_valid), 0);
      check32("rst_result", result, 32'h0);
      #1;
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].lat);
      end
      wait_drain();

      // Backpressure: hold the result while a competing request is presented
      out_ready = 1'b0;
      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 27);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk_n);
         n++;
      end
      check_int("bp_out_valid", int'(out_valid), 1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_n);
         check32("bp_result_hold", result, 32'h40400000);
         check_int("bp_in_ready", int'(in_ready), 0);
         check_int("bp_valid_hold", int'(out_valid), 1);
         #1;
         in_valid = 1'b1;
         a_in     = 32'h3F800000;
         b_in     = 32'h00000000;
      end
      @(negedge clk_n); #1;
      out_ready = 1'b1;
      @(negedge clk_n); #1;
      check_int("bp_idle_in_ready", int'(in_ready), 1);
      check_int("bp_idle_out_valid", int'(out_valid), 0);
      in_valid = 1'b0;
      wait_drain();

      // Reset in the middle of a division
      @(posedge clk_n); #1;
      a_in     = 32'h40C00000;
      b_in     = 32'h40000000;
      in_valid = 1'b1;
      @(negedge clk_n); #1;
      in_valid = 1'b0;
      repeat (10) @(negedge clk_n);
      #2;
      check_int("mid_busy", int'(in_ready), 0);
      rst_n = 1'b0;
      #1;
      check_int("mid_rst_in_ready", int'(in_ready), 1);
      check_int("mid_rst_out_valid", int'(out_valid), 0);
      check32("mid_rst_result", result, 32'h0);
      @(posedge clk_n); #1;
      rst_n = 1'b1;

      do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 27);
      do_op(32'h40C00000, 32'h40000000, 32'h40400000, 27);
      wait_drain();

      repeat (5) @(posedge clk_n);
      check_int("queue_empty", exp_q.size(), 0);
      check_int("lat_queue_empty", lat_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
